shift_add_multiplier: RTL and testbench

Sequential signed multiply-accumulate that computes product = multiplicand × multiplier + addend, one multiplier bit per clock. It is the inverse companion of the restoring divider in the FM datapath. It rebuilds a dividend from a quotient/divisor/remainder triple for self-check, and it serves gain and scaling stages that can tolerate multi-cycle latency in exchange for no DSP multiplier. Operands are two's complement. The block uses sign-magnitude internally: multiply the magnitudes, apply the sign, then add the addend.

---
 rtl/mult_pkg.sv | 17 +
 rtl/abs_sign.sv | 18 +
 rtl/shift_add_multiplier.sv | 112 +++++++++++
 tb/tb_shift_add_multiplier.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and default widths for the shift-add multiplier.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mult_pkg;

  // Default widths, shared with the divider instantiation site
  localparam int DEF_A_WIDTH = 32;  // multiplicand / quotient width
  localparam int DEF_B_WIDTH = 16;  // multiplier / divisor width
  localparam int DEF_C_WIDTH = 16;  // addend / remainder width

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } mult_state_t;

endpackage

// File: rtl/abs_sign.sv
// Splits a two's complement value into unsigned magnitude and sign bit.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the input.
module abs_sign #(
  parameter int W = 16
) (
  input  logic [W-1:0] value,
  output logic [W-1:0] magnitude,
  output logic         sign
);

  // The most negative value maps to 2^(W-1), which still fits W unsigned bits
  always_comb begin
    sign      = value[W-1];
    magnitude = sign ? (~value + 1'b1) : value;
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Signed multiply-accumulate: product = multiplicand * multiplier + addend, one multiplier bit per clock.
// Latency: B_WIDTH+2 cycles from accepted start to done; throughput one result per B_WIDTH+2 cycles.
// Backpressure: start is accepted only in IDLE; start while busy is dropped, not queued.
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int A_WIDTH = DEF_A_WIDTH,
  parameter int B_WIDTH = DEF_B_WIDTH,
  parameter int C_WIDTH = DEF_C_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [A_WIDTH-1:0]         multiplicand,
  input  logic [B_WIDTH-1:0]         multiplier,
  input  logic [C_WIDTH-1:0]         addend,
  output logic                       busy,
  output logic                       done,
  output logic [A_WIDTH+B_WIDTH-1:0] product
);

  localparam int P_WIDTH = A_WIDTH + B_WIDTH;
  localparam int CNT_W   = $clog2(B_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(B_WIDTH - 1);

  mult_state_t        state;
  mult_state_t        state_nxt;

  logic [A_WIDTH-1:0] a_mag;
  logic               a_sign;
  logic [B_WIDTH-1:0] b_mag;
  logic               b_sign;

  logic [A_WIDTH-1:0] mcand_mag;
  logic [B_WIDTH-1:0] mplier_mag;
  logic               neg;
  logic [P_WIDTH-1:0] addend_ext;
  logic [P_WIDTH-1:0] acc;
  logic [CNT_W-1:0]   count;

  abs_sign #(.W(A_WIDTH)) u_abs_a (
    .value     (multiplicand),
    .magnitude (a_mag),
    .sign      (a_sign)
  );

  abs_sign #(.W(B_WIDTH)) u_abs_b (
    .value     (multiplier),
    .magnitude (b_mag),
    .sign      (b_sign)
  );

  // Busy covers RUN and FIX; it drops in the done cycle because state is back in IDLE
  assign busy = (state != IDLE);

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: fixed B_WIDTH iterations in RUN, no early exit on zero operands
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (count == LAST_BIT) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture operands on accept, shift-add in RUN, apply sign and addend in FIX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_mag  <= '0;
      mplier_mag <= '0;
      neg        <= 1'b0;
      addend_ext <= '0;
      acc        <= '0;
      count      <= '0;
      product    <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand_mag  <= a_mag;
            mplier_mag <= b_mag;
            neg        <= a_sign ^ b_sign;
            addend_ext <= {{(P_WIDTH - C_WIDTH){addend[C_WIDTH-1]}}, addend};
            acc        <= '0;
            count      <= '0;
          end
        end
        RUN: begin
          if (mplier_mag[0]) acc <= acc + (P_WIDTH'(mcand_mag) << count);
          mplier_mag <= mplier_mag >> 1;
          count      <= count + CNT_W'(1);
        end
        FIX: begin
          // Magnitude product is at most 2^(P_WIDTH-2), so negation and addend cannot overflow
          product <= (neg ? (~acc + 1'b1) : acc) + addend_ext;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed self-checking bench for shift_add_multiplier.
// Latency: expects done exactly B_WIDTH+2 = 18 cycles after the accepting cycle.
// Backpressure: exercises start held high while busy and reset mid-operation.
module tb_shift_add_multiplier;

  localparam int A_W = 32;
  localparam int B_W = 16;
  localparam int C_W = 16;
  localparam int P_W = A_W + B_W;
  localparam int DONE_CYC = B_W + 2;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [A_W-1:0] multiplicand;
  logic [B_W-1:0] multiplier;
  logic [C_W-1:0] addend;
  logic           busy;
  logic           done;
  logic [P_W-1:0] product;

  int n_cmp;
  int n_bad;

  shift_add_multiplier #(
    .A_WIDTH (A_W),
    .B_WIDTH (B_W),
    .C_WIDTH (C_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .addend       (addend),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint prod_s();
    return longint'($signed(product));
  endfunction

  // One operation: start in cycle 0, then watch cycles 1..40 sampling on the falling edge
  task automatic run_op(input string tag, input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                        input logic [C_W-1:0] c, input longint exp);
    int done_cyc;
    int busy_cnt;
    logic busy_at_done;
    done_cyc     = -1;
    busy_cnt     = 0;
    busy_at_done = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; multiplicand = a; multiplier = b; addend = c;
    for (int k = 1; k <= 40 && done_cyc < 0; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        start = 1'b0;
        // operand changes after accept must not matter
        multiplicand = $urandom; multiplier = 16'($urandom); addend = 16'($urandom);
      end
      @(negedge clk);
      if (done) begin
        done_cyc     = k;
        busy_at_done = busy;
      end else if (busy && k <= DONE_CYC - 1) begin
        busy_cnt++;
      end
    end
    chk_eq({tag, "_done_cycle"}, done_cyc, DONE_CYC);
    chk_eq({tag, "_product"}, prod_s(), exp);
    chk_eq({tag, "_busy_cycles"}, busy_cnt, DONE_CYC - 1);
    chk_eq({tag, "_busy_at_done"}, longint'(busy_at_done), 0);
  endtask

  initial begin
    int done_cnt;
    int done_c1;
    int done_c2;
    longint prod1;
    longint prod2;
    int stray;

    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    start = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    addend       = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_busy", longint'(busy), 0);
    chk_eq("rst_done", longint'(done), 0);
    chk_eq("rst_product", prod_s(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    stray = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done || busy || product != '0) stray++;
    end
    chk_eq("post_rst_idle", stray, 0);

    // Main function and sign combinations
    run_op("pos_pos", 32'sd1000, 16'sd7, 16'sd3, 64'sd7003);
    run_op("neg_pos", -32'sd1000, 16'sd7, 16'sd0, -64'sd7000);
    run_op("pos_neg", 32'sd1000, -16'sd7, -16'sd3, -64'sd7003);
    run_op("neg_neg", -32'sd1000, -16'sd7, 16'sd5, 64'sd7005);
    run_op("zero", 32'sd0, 16'sh8000, -16'sd1, -64'sd1);

    // Extremes
    run_op("min_min", 32'sh80000000, 16'sh8000, 16'sd0, 64'sd70368744177664);
    run_op("max_min", 32'sh7fffffff, 16'sh8000, 16'sd32767, -64'sd70368744112129);

    // start held high for 40 cycles; operands scrambled while busy
    done_cnt = 0; done_c1 = -1; done_c2 = -1; prod1 = 0; prod2 = 0;
    @(posedge clk); #1;
    start = 1'b1; multiplicand = 32'sd1000; multiplier = 16'sd7; addend = 16'sd3;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk); #1;
      if (k >= 40) start = 1'b0;
      if (k == DONE_CYC) begin
        multiplicand = 32'sd12; multiplier = -16'sd5; addend = 16'sd1;
      end else begin
        multiplicand = $urandom; multiplier = 16'($urandom); addend = 16'($urandom);
      end
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin done_c1 = k; prod1 = prod_s(); end
        if (done_cnt == 2) begin done_c2 = k; prod2 = prod_s(); end
      end
    end
    chk_eq("held_done_count", done_cnt, 2);
    chk_eq("held_done1_cycle", done_c1, DONE_CYC);
    chk_eq("held_done2_cycle", done_c2, 2 * DONE_CYC);
    chk_eq("held_product1", prod1, 64'sd7003);
    chk_eq("held_product2", prod2, -64'sd59);
    // drain the third operation accepted in cycle 36
    for (int k = 0; k < 40 && (busy || done); k++) @(negedge clk);
    chk_eq("held_drain_idle", longint'(busy), 0);

    // Reset pulsed in cycle 8 of an operation
    @(posedge clk); #1;
    start = 1'b1; multiplicand = 32'sd1000; multiplier = 16'sd7; addend = 16'sd3;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk_eq("midrst_busy", longint'(busy), 0);
    chk_eq("midrst_done", longint'(done), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    stray = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done || busy) stray++;
    end
    chk_eq("midrst_no_done", stray, 0);
    run_op("after_rst", 32'sd12, 16'sd12, 16'sd0, 64'sd144);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
